// File: rtl/data_mem_pipe_pkg.sv
// Shared constants, width helpers and response entry type for data_mem_pipe.
// Optional misaligned-access checking is enabled with DATA_MEM_PIPE_MISALIGN_CHK_EN.
package data_mem_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 10;
  localparam int RD_LAT_DEF = 2;

  // Byte lanes per word and number of byte-offset address bits (DATA_W >= 16)
  function automatic int be_w(input int dw);
    return dw / 8;
  endfunction

  function automatic int boff_w(input int dw);
    return $clog2(dw / 8);
  endfunction

  localparam int BE_W_DEF   = DATA_W_DEF / 8;
  localparam int BOFF_W_DEF = $clog2(BE_W_DEF);

  // One queued response at the default word width
  typedef struct packed {
    logic [DATA_W_DEF-1:0] rdata;
    logic                  err;
  } rsp_entry_t;

endpackage

// File: rtl/data_mem_pipe_if.sv
// Request/response bus between the CPU MEM stage (master) and data_mem_pipe (slave).
// rsp_err exists only when DATA_MEM_PIPE_MISALIGN_CHK_EN is defined.
interface data_mem_pipe_if import data_mem_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) ();

  localparam int BE_W = be_w(DATA_W);
  localparam int AW   = ADDR_W + boff_w(DATA_W);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [AW-1:0]     req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
`ifdef DATA_MEM_PIPE_MISALIGN_CHK_EN
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
`else
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
`endif

endinterface

// File: rtl/data_mem_pipe_resp_fifo.sv
// Synchronous response FIFO with fall-through: when empty, a pushed entry is
// visible on the output in the same cycle and is not stored if popped at once.
module resp_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             empty;
  logic             push;
  logic             deq;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty     = (count == '0);
  assign out_valid = !empty || in_valid;
  assign out_data  = empty ? in_data : store[rd_ptr];
  assign deq       = !empty && out_ready;
  // An entry bypasses storage only when the FIFO is empty and it is taken now
  assign push      = in_valid && !(empty && out_ready);

  // Storage array, no reset needed since count gates visibility
  always_ff @(posedge clk) begin
    if (push) store[wr_ptr] <= in_data;
  end

  // Pointer and occupancy tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (deq)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/data_mem_pipe.sv
// Pipelined single-port data memory with byte-lane writes, RD_LAT-cycle reads
// and valid/ready request/response handshakes (RD_LAT legal range 1..4).
// Define DATA_MEM_PIPE_MISALIGN_CHK_EN to flag accesses with nonzero
// byte-offset bits: such writes are dropped, such reads return 0 with rsp_err.
module data_mem_pipe import data_mem_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input logic            clk,
  input logic            rst,
  data_mem_pipe_if.slave bus
);

  localparam int BE_W   = be_w(DATA_W);
  localparam int BOFF_W = boff_w(DATA_W);
  localparam int AW     = ADDR_W + BOFF_W;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int CNT_W  = $clog2(RD_LAT + 2);
`ifdef DATA_MEM_PIPE_MISALIGN_CHK_EN
  localparam int ENT_W  = DATA_W + 1;
`else
  localparam int ENT_W  = DATA_W;
`endif

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] word_idx;
  logic              req_rdy;
  logic              acc;
  logic              rd_acc;
  logic              wr_acc;
  logic              pop;
  logic [CNT_W-1:0]  outstanding;
  logic [ENT_W-1:0]  rd_ent;
  logic [RD_LAT-1:0] vld_p;
  logic [ENT_W-1:0]  ent_p [RD_LAT];
  logic              rsp_vld;
  logic [ENT_W-1:0]  head;

  // Word index wraps naturally at 2**ADDR_W; byte offset handled below
  assign word_idx = bus.req_addr[AW-1:BOFF_W];
  assign req_rdy  = (outstanding < CNT_W'(RD_LAT + 1));
  assign acc      = bus.req_valid && req_rdy;
  assign pop      = rsp_vld && bus.rsp_ready;

`ifdef DATA_MEM_PIPE_MISALIGN_CHK_EN
  logic misalign;
  assign misalign = |bus.req_addr[BOFF_W-1:0];
  assign wr_acc   = acc && bus.req_we && !misalign;
  assign rd_acc   = acc && !bus.req_we;
  assign rd_ent   = misalign ? {{DATA_W{1'b0}}, 1'b1} : {mem[word_idx], 1'b0};
`else
  logic unused_boff;
  assign unused_boff = ^bus.req_addr[BOFF_W-1:0];
  assign wr_acc      = acc && bus.req_we;
  assign rd_acc      = acc && !bus.req_we;
  assign rd_ent      = mem[word_idx];
`endif

  // Byte-lane RAM write; contents are intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int i = 0; i < BE_W; i++) begin
        if (bus.req_be[i]) mem[word_idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
      end
    end
  end

  // Stage 0 captures the RAM word, later stages shift it towards the FIFO
  always_ff @(posedge clk) begin
    if (rd_acc) ent_p[0] <= rd_ent;
    for (int j = 1; j < RD_LAT; j++) ent_p[j] <= ent_p[j-1];
  end

  // Valid shift pipeline travelling alongside the read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= rd_acc;
      for (int j = 1; j < RD_LAT; j++) vld_p[j] <= vld_p[j-1];
    end
  end

  // Reads in flight or queued; caps occupancy so the FIFO cannot overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      case ({rd_acc, pop})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: ;
      endcase
    end
  end

  resp_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (RD_LAT + 1)
  ) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (vld_p[RD_LAT-1]),
    .in_data   (ent_p[RD_LAT-1]),
    .out_valid (rsp_vld),
    .out_ready (bus.rsp_ready),
    .out_data  (head)
  );

  // Data outputs forced to zero when no response is presented
  assign bus.req_ready = req_rdy;
  assign bus.rsp_valid = rsp_vld;
  assign bus.rsp_rdata = rsp_vld ? head[ENT_W-1 -: DATA_W] : '0;
`ifdef DATA_MEM_PIPE_MISALIGN_CHK_EN
  assign bus.rsp_err   = rsp_vld & head[0];
`endif

endmodule
